instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumer side of the program counter: reads the current PC value and fetches the instruction at that address from instruction memory over a req/gnt/rvalid interface.
- Pulses the PC's increment enable on each accepted request.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Sits between the program counter, instruction memory and decode; handles branch redirects by flushing.

Parameters:
ADDR_W, 4, width of PC / instruction address.
DATA_W, 8, instruction word width.
DEPTH, 2, fetch buffer entries (power of 2, >=2).

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
pc  input  ADDR_W  current program counter value.
redirect  input  1  PC is being loaded (branch/jump) this cycle; flush in-flight fetch.
pc_inc  output  1  increment enable to the program counter.
mem_req  output  1  instruction memory read request.
mem_addr  output  ADDR_W  request address.
mem_gnt  input  1  memory accepts request this cycle.
mem_rvalid  input  1  read data valid; in order, at least 1 cycle after grant.
mem_rdata  input  DATA_W  read data.
instr_valid  output  1  buffered instruction available.
instr_data  output  DATA_W  head instruction word.
instr_addr  output  ADDR_W  address of head instruction.
instr_ready  input  1  decode consumes head when instr_valid is also high.

Behaviour:
- Reset: state=REQ, FIFO count=0, pend_addr=0, outputs instr_data=0 and instr_addr=0. While reset is high, mem_req=0, pc_inc=0 and instr_valid=0.
- At most one outstanding memory request.
- Space condition: a request is allowed only when count < DEPTH, counting the outstanding slot. This guarantees the FIFO never overflows.
- REQ state:
  - mem_req = (count_after_pop < DEPTH) and not redirect.
  - mem_addr = pc, combinational.
  - On mem_req and mem_gnt: pc_inc=1 in the same cycle, pend_addr <= pc, next state WAIT.
  - mem_rvalid in REQ is ignored.
- WAIT state:
  - mem_req=0.
  - On mem_rvalid: push {pend_addr, mem_rdata} into the FIFO, next state REQ.
  - On redirect without rvalid: next state DROP.
  - On redirect with rvalid in the same cycle: data discarded, next state REQ.
- DROP state: mem_req=0; on mem_rvalid, discard the data and go to REQ. A redirect in DROP keeps the state at DROP.
- pc_inc is never high in a cycle with redirect (mem_req is suppressed).
- redirect in any state: FIFO count <= 0 next cycle, and instr_valid drops the following cycle. A pop in the same cycle is irrelevant.
- FIFO:
  - instr_valid = (count != 0); instr_data and instr_addr come from the head entry, registered storage.
  - Pop on instr_valid and instr_ready.
  - Push and pop in the same cycle: count unchanged, order preserved. Read and write pointers wrap modulo DEPTH.
- Latency: grant at cycle t, rvalid at t+k, instr_valid at t+k+1. Best-case sustained throughput is 1 instruction per 2 cycles.
- mem_addr is held stable while mem_req is high without grant, because pc changes only via pc_inc (granted) or redirect (request dropped).
- Address arithmetic belongs to the PC. instr_addr wraps naturally (address F followed by 0 for ADDR_W=4).
- Reset mid-WAIT: returns to REQ. A stale rvalid arriving after reset is ignored as a REQ-state spurious rvalid.

Test Plan:
- Reset, pc model starts at 0, gnt same cycle, rvalid 1 cycle later with rdata=0xA0+addr, instr_ready=1 -> instr stream (0,A0),(1,A1),(2,A2),(3,A3), one per 2 cycles, with one pc_inc pulse per grant.
- instr_ready=0 from start -> exactly 2 entries buffered (addr 0,1), mem_req stays 0, pc holds at 2. Raise ready -> entries drain in order and fetch resumes at addr 2.
- mem_gnt held low 3 cycles with pc=5 -> mem_req=1 and mem_addr=5 stable for those cycles, no pc_inc until the gnt cycle.
- Redirect in WAIT (pc loaded to 9), rvalid 2 cycles later with 0xEE -> 0xEE never appears, FIFO empties, next mem_addr=9, first instr (9,A9).
- Redirect in the same cycle as rvalid -> data dropped, no pc_inc that cycle, next request at the new pc.
- pc=F fetch then 0 -> instr_addr F then 0. Reset asserted in WAIT then a late rvalid -> instr_valid stays 0 and the next request uses the pc after reset.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches instructions from instruction memory at the address held by the
// program counter and hands them to decode through a small in-order buffer.
//
// Ports:
//   clk          clock, every state update happens on its rising edge
//   reset        synchronous active-high reset
//   pc           current program counter value (used as the fetch address)
//   redirect     PC is being loaded this cycle; in-flight and buffered work
//                is thrown away
//   pc_inc       increment enable to the PC, pulses once per granted request
//   mem_req      instruction memory read request
//   mem_addr     request address (follows pc)
//   mem_gnt      memory accepts the request this cycle
//   mem_rvalid   read data valid, in order, at least one cycle after grant
//   mem_rdata    read data
//   instr_valid  a buffered instruction is available at the head
//   instr_data   head instruction word
//   instr_addr   address the head instruction was fetched from
//   instr_ready  decode consumes the head when instr_valid is also high
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    output logic              pc_inc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // REQ: may issue a request; WAIT: one request outstanding, its data is
    // wanted; DROP: one request outstanding, its data must be discarded.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pend_addr;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_after_pop;
    logic              push;
    logic              pop;

    assign mem_addr    = pc;
    assign instr_valid = !reset && (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr_data  = data_mem[rd_ptr];
    assign instr_addr  = addr_mem[rd_ptr];

    // Only one request is ever outstanding and requests are issued from REQ
    // alone, so in REQ the buffer occupancy after this cycle's pop is the
    // whole space budget: a new request needs a free slot for its data.
    assign count_after_pop = pop ? (count - CNT_ONE) : count;

    // Next-state and handshake outputs. A redirect suppresses the request so
    // the PC never sees an increment in the same cycle it is being loaded.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        pc_inc     = 1'b0;
        push       = 1'b0;
        unique case (state)
            REQ: begin
                mem_req = !reset && !redirect && (count_after_pop < DEPTH_CNT);
                pc_inc  = mem_req && mem_gnt;
                if (pc_inc) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    push       = !redirect;
                    state_next = REQ;
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (mem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Remember which address the outstanding request was for, so the
    // returning data can be tagged with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_addr <= '0;
        end else if (pc_inc) begin
            pend_addr <= pc;
        end
    end

    // Fetch buffer. Storage is cleared on reset so the head outputs read
    // zero afterwards; a redirect only needs to empty it logically.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= pend_addr;
                data_mem[wr_ptr] <= mem_rdata;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit together with a small PC model and a memory model
// that grants and returns data in order. A queue-based model of the fetch
// buffer predicts every output each cycle; scripted scenarios add literal
// expectations on the instruction stream.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;
    localparam int EW     = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic              pc_inc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ready;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .redirect   (redirect),
        .pc_inc     (pc_inc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_addr (instr_addr),
        .instr_ready(instr_ready)
    );

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    // Behavioural model: buffered {addr,data} entries, whether a request is
    // outstanding, and whether its data is to be thrown away.
    logic [EW-1:0]     fifo_q[$];
    bit                busy = 0;
    bit                discard = 0;
    logic [ADDR_W-1:0] pend_a = '0;
    logic [ADDR_W-1:0] pc_m = '0;

    // Memory model: at most one response pending.
    bit                mem_pend = 0;
    int                mem_cnt = 0;
    logic [DATA_W-1:0] mem_d = '0;
    int                mem_lat = 1;
    bit                force_ee = 0;
    bit                rand_data = 0;

    // Inputs and expectations of the current cycle.
    bit                cur_rst, cur_redir, cur_rdy, cur_gnt, cur_rvalid;
    logic [ADDR_W-1:0] cur_tgt;
    bit                exp_valid, exp_pop, exp_req, exp_inc;

    // Observed instruction stream and pc_inc pulses.
    logic [EW-1:0]     consumed[$];
    int                consume_cyc[$];
    int                inc_seen = 0;
    bit                saw_ee = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] entry(input int a, input int d);
        return {ADDR_W'(a), DATA_W'(d)};
    endfunction

    function automatic logic [EW-1:0] consumedAt(input int i);
        if (i < consumed.size()) return consumed[i];
        return 'x;
    endfunction

    task automatic applyStimulus(input bit rst, input bit redir, input logic [ADDR_W-1:0] tgt,
                                 input bit rdy, input bit gnt_en);
        cur_rst    = rst;
        cur_redir  = redir;
        cur_tgt    = tgt;
        cur_rdy    = rdy;
        cur_gnt    = gnt_en && !mem_pend;
        cur_rvalid = mem_pend && (mem_cnt == 0);
        reset       = rst;
        redirect    = redir;
        instr_ready = rdy;
        mem_gnt     = cur_gnt;
        mem_rvalid  = cur_rvalid;
        mem_rdata   = cur_rvalid ? mem_d : DATA_W'($urandom);
        pc          = pc_m;
    endtask

    task automatic checkOutput();
        exp_valid = !cur_rst && (fifo_q.size() != 0);
        exp_pop   = exp_valid && cur_rdy;
        exp_req   = !cur_rst && !busy && !cur_redir && ((fifo_q.size() - int'(exp_pop)) < DEPTH);
        exp_inc   = exp_req && cur_gnt;
        check("mem_req", 32'(mem_req), 32'(exp_req));
        check("pc_inc", 32'(pc_inc), 32'(exp_inc));
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_req) check("mem_addr", 32'(mem_addr), 32'(pc_m));
        if (exp_valid) begin
            check("instr_addr", 32'(instr_addr), 32'(fifo_q[0][EW-1:DATA_W]));
            check("instr_data", 32'(instr_data), 32'(fifo_q[0][DATA_W-1:0]));
        end
        if (instr_valid && instr_ready) begin
            consumed.push_back({instr_addr, instr_data});
            consume_cyc.push_back(cycle_no);
            if (instr_data == 8'hEE) saw_ee = 1;
        end
        if (pc_inc) inc_seen++;
    endtask

    task automatic updateModel();
        // Memory side first, while pc_m still holds the requested address.
        if (cur_rvalid) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (exp_inc) begin
            mem_pend = 1;
            mem_cnt  = mem_lat - 1;
            if (force_ee) mem_d = 8'hEE;
            else if (rand_data) mem_d = DATA_W'($urandom);
            else mem_d = DATA_W'(8'hA0 + int'(pc_m));
            force_ee = 0;
        end
        if (cur_rst) begin
            fifo_q.delete();
            busy    = 0;
            discard = 0;
            pc_m    = cur_tgt;
        end else begin
            if (exp_pop) void'(fifo_q.pop_front());
            if (busy && cur_rvalid) begin
                if (!discard && !cur_redir) fifo_q.push_back({pend_a, mem_d});
                busy    = 0;
                discard = 0;
            end else if (busy && cur_redir) begin
                discard = 1;
            end
            if (cur_redir) fifo_q.delete();
            if (exp_inc) begin
                busy    = 1;
                discard = 0;
                pend_a  = pc_m;
            end
            if (cur_redir) pc_m = cur_tgt;
            else if (exp_inc) pc_m = pc_m + 1'b1;
        end
    endtask

    task automatic beginCycle(input bit rst, input bit redir, input logic [ADDR_W-1:0] tgt,
                              input bit rdy, input bit gnt_en);
        applyStimulus(rst, redir, tgt, rdy, gnt_en);
        #1;
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        updateModel();
        cycle_no++;
        @(negedge clk);
    endtask

    task automatic stepCycle(input bit rst, input bit redir, input logic [ADDR_W-1:0] tgt,
                             input bit rdy, input bit gnt_en);
        beginCycle(rst, redir, tgt, rdy, gnt_en);
        endCycle();
    endtask

    task automatic doReset(input logic [ADDR_W-1:0] pc0);
        stepCycle(1, 0, pc0, 0, 0);
        stepCycle(1, 0, pc0, 0, 0);
        #1;
        check("reset_instr_data", 32'(instr_data), 32'h0);
        check("reset_instr_addr", 32'(instr_addr), 32'h0);
        check("reset_instr_valid", 32'(instr_valid), 32'h0);
        check("reset_mem_req", 32'(mem_req), 32'h0);
    endtask

    task automatic waitGrant(input string name);
        int n;
        n = 0;
        while (!mem_pend && n < 20) begin
            stepCycle(0, 0, '0, 1, 1);
            n++;
        end
        check(name, 32'(mem_pend), 32'h1);
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        pc          = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
        @(negedge clk);

        // Streaming fetch from 0, grant immediate, data one cycle later.
        doReset(4'h0);
        mem_lat = 1;
        consumed.delete();
        consume_cyc.delete();
        inc_seen = 0;
        for (int i = 0; i < 9; i++) stepCycle(0, 0, '0, 1, 1);
        check("t1_count", 32'(consumed.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t1_stream", 32'(consumedAt(i)), 32'(entry(i, 8'hA0 + i)));
        for (int i = 0; i + 1 < consume_cyc.size(); i++)
            check("t1_spacing", 32'(consume_cyc[i+1] - consume_cyc[i]), 32'd2);
        check("t1_pc_inc", 32'(inc_seen), 32'd5);

        // Decode stalled: buffer fills with two entries and fetch stops.
        doReset(4'h0);
        inc_seen = 0;
        for (int i = 0; i < 8; i++) stepCycle(0, 0, '0, 0, 1);
        check("t2_pc_inc", 32'(inc_seen), 32'd2);
        check("t2_valid", 32'(instr_valid), 32'h1);
        check("t2_head", 32'(instr_addr), 32'h0);
        check("t2_req", 32'(mem_req), 32'h0);
        consumed.delete();
        for (int i = 0; i < 8; i++) stepCycle(0, 0, '0, 1, 1);
        for (int i = 0; i < 4; i++) check("t2_stream", 32'(consumedAt(i)), 32'(entry(i, 8'hA0 + i)));

        // Grant withheld: request and address stay put, no increment.
        doReset(4'h0);
        stepCycle(0, 1, 4'h5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            beginCycle(0, 0, '0, 1, 0);
            check("t3_req_held", 32'(mem_req), 32'h1);
            check("t3_addr_held", 32'(mem_addr), 32'h5);
            check("t3_no_inc", 32'(pc_inc), 32'h0);
            endCycle();
        end
        beginCycle(0, 0, '0, 1, 1);
        check("t3_inc_on_gnt", 32'(pc_inc), 32'h1);
        endCycle();
        consumed.delete();
        for (int i = 0; i < 4; i++) stepCycle(0, 0, '0, 1, 1);
        check("t3_first", 32'(consumedAt(0)), 32'(entry(5, 8'hA5)));

        // Redirect while waiting; the late 0xEE must never reach decode.
        doReset(4'h7);
        mem_lat  = 3;
        force_ee = 1;
        saw_ee   = 0;
        waitGrant("t4_grant");
        stepCycle(0, 1, 4'h9, 1, 1);
        mem_lat = 1;
        consumed.delete();
        for (int i = 0; i < 10; i++) stepCycle(0, 0, '0, 1, 1);
        check("t4_no_ee", 32'(saw_ee), 32'h0);
        check("t4_first", 32'(consumedAt(0)), 32'(entry(9, 8'hA9)));

        // Redirect in the same cycle the data returns.
        mem_lat = 2;
        waitGrant("t5_grant");
        begin
            int n;
            n = 0;
            while (!(mem_pend && mem_cnt == 0) && n < 20) begin
                stepCycle(0, 0, '0, 1, 1);
                n++;
            end
        end
        beginCycle(0, 1, 4'hC, 1, 1);
        check("t5_rvalid_here", 32'(mem_rvalid), 32'h1);
        check("t5_no_inc", 32'(pc_inc), 32'h0);
        endCycle();
        mem_lat = 1;
        consumed.delete();
        for (int i = 0; i < 6; i++) stepCycle(0, 0, '0, 1, 1);
        check("t5_first", 32'(consumedAt(0)), 32'(entry(12, 8'hAC)));

        // Address wrap from F to 0.
        stepCycle(0, 1, 4'hF, 1, 1);
        consumed.delete();
        for (int i = 0; i < 8; i++) stepCycle(0, 0, '0, 1, 1);
        check("t6_wrap_f", 32'(consumedAt(0)), 32'(entry(15, 8'hAF)));
        check("t6_wrap_0", 32'(consumedAt(1)), 32'(entry(0, 8'hA0)));

        // Reset while waiting, then the stale data shows up.
        mem_lat = 4;
        waitGrant("t7_grant");
        stepCycle(1, 0, 4'h3, 1, 1);
        mem_lat = 1;
        consumed.delete();
        for (int i = 0; i < 4; i++) begin
            beginCycle(0, 0, '0, 1, 1);
            check("t7_quiet", 32'(instr_valid), 32'h0);
            endCycle();
        end
        for (int i = 0; i < 4; i++) stepCycle(0, 0, '0, 1, 1);
        check("t7_first", 32'(consumedAt(0)), 32'(entry(3, 8'hA3)));

        // Randomised traffic against the model.
        rand_data = 1;
        for (int i = 0; i < 3000; i++) begin
            mem_lat = 1 + int'($urandom_range(0, 2));
            stepCycle(($urandom_range(0, 99) == 0),
                      ($urandom_range(0, 99) < 5),
                      ADDR_W'($urandom),
                      ($urandom_range(0, 99) < 60),
                      ($urandom_range(0, 99) < 70));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
